// File: rtl/reg_file_8x8_if.sv
// Operand-path bus for the 8x8 register file: write port, two read addresses,
// registered read data and the write status flag.
interface reg_file_8x8_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic [DATA_WIDTH-1:0] IN;
   logic [ADDR_WIDTH-1:0] INADDRESS;
   logic                  WRITE;
   logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
   logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
   logic [DATA_WIDTH-1:0] OUT1;
   logic [DATA_WIDTH-1:0] OUT2;
   logic                  BUSY;

   modport master (
      output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
      input  OUT1, OUT2, BUSY
   );

   modport slave (
      input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
      output OUT1, OUT2, BUSY
   );
endinterface

// File: rtl/reg_file_8x8.sv
// Eight-entry register file, falling-edge clocked, two registered read ports
// with write-to-read bypass and a one-cycle BUSY flag after every write.
module reg_file_8x8 #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input logic           CLK,
   input logic           RESET,
   reg_file_8x8_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_out1;
   logic [DATA_WIDTH-1:0] r_out2;
   logic                  r_busy;

   logic w_hit1;
   logic w_hit2;

   assign w_hit1 = (bus.INADDRESS == bus.OUT1ADDRESS);
   assign w_hit2 = (bus.INADDRESS == bus.OUT2ADDRESS);

   // An unknown WRITE falls through to the hold branch, keeping X out of the array.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         always_ff @(negedge CLK or posedge RESET) begin
            if (RESET) begin
               r_mem[gi] <= '0;
            end else if (bus.WRITE && (bus.INADDRESS == ADDR_WIDTH'(gi))) begin
               r_mem[gi] <= bus.IN;
            end
         end
      end
   endgenerate

   always_ff @(negedge CLK or posedge RESET) begin
      if (RESET) begin
         r_out1 <= '0;
         r_out2 <= '0;
         r_busy <= 1'b0;
      end else begin
         if (bus.WRITE && w_hit1) r_out1 <= bus.IN;
         else                     r_out1 <= r_mem[bus.OUT1ADDRESS];

         if (bus.WRITE && w_hit2) r_out2 <= bus.IN;
         else                     r_out2 <= r_mem[bus.OUT2ADDRESS];

         if (bus.WRITE) r_busy <= 1'b1;
         else           r_busy <= 1'b0;
      end
   end

   assign bus.OUT1 = r_out1;
   assign bus.OUT2 = r_out2;
   assign bus.BUSY = r_busy;
endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed bench for reg_file_8x8: inputs change at rising edges, the DUT acts
// on falling edges, outputs are checked at the following rising edge.
module tb_reg_file_8x8;
   logic CLK;
   logic RESET;
   int   checks;
   int   errors;

   reg_file_8x8_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

   reg_file_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b1;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs at a rising edge, let one falling edge pass, return at the next rising edge.
   task automatic cyc(input logic w, input logic [2:0] ia, input logic [7:0] d,
                      input logic [2:0] a1, input logic [2:0] a2);
      bus.WRITE       = w;
      bus.INADDRESS   = ia;
      bus.IN          = d;
      bus.OUT1ADDRESS = a1;
      bus.OUT2ADDRESS = a2;
      @(posedge CLK);
      $display("t=%0t W=%b IA=%0d IN=%h A1=%0d A2=%0d -> OUT1=%h OUT2=%h BUSY=%b",
               $time, w, ia, d, a1, a2, bus.OUT1, bus.OUT2, bus.BUSY);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RESET  = 1'b1;
      bus.WRITE = 1'b0; bus.INADDRESS = '0; bus.IN = '0;
      bus.OUT1ADDRESS = '0; bus.OUT2ADDRESS = '0;
      @(posedge CLK); @(posedge CLK);
      check("rst_out1", bus.OUT1, 8'h00);
      check("rst_out2", bus.OUT2, 8'h00);
      check("rst_busy", {7'd0, bus.BUSY}, 8'h00);
      RESET = 1'b0;

      // 1: reset between edges clears outputs immediately
      cyc(1'b1, 3'd3, 8'h55, 3'd3, 3'd3);
      check("t1_bypass", bus.OUT1, 8'h55);
      check("t1_busy", {7'd0, bus.BUSY}, 8'h01);
      #2 RESET = 1'b1;
      #1;
      check("t1_rst_out1", bus.OUT1, 8'h00);
      check("t1_rst_out2", bus.OUT2, 8'h00);
      check("t1_rst_busy", {7'd0, bus.BUSY}, 8'h00);
      @(posedge CLK);
      RESET = 1'b0;
      cyc(1'b0, 3'd0, 8'h00, 3'd3, 3'd3);
      check("t1_r3_cleared", bus.OUT1, 8'h00);

      // 2: write then read
      cyc(1'b1, 3'd2, 8'd5, 3'd0, 3'd0);
      check("t2_busy_w1", {7'd0, bus.BUSY}, 8'h01);
      cyc(1'b1, 3'd5, 8'd10, 3'd0, 3'd0);
      check("t2_busy_w2", {7'd0, bus.BUSY}, 8'h01);
      cyc(1'b0, 3'd0, 8'd0, 3'd2, 3'd5);
      check("t2_out1", bus.OUT1, 8'd5);
      check("t2_out2", bus.OUT2, 8'd10);
      check("t2_busy_rd", {7'd0, bus.BUSY}, 8'h00);

      // 3: bypass on both ports
      cyc(1'b1, 3'd4, 8'hAA, 3'd0, 3'd0);
      cyc(1'b1, 3'd4, 8'h3C, 3'd4, 3'd4);
      check("t3_byp_out1", bus.OUT1, 8'h3C);
      check("t3_byp_out2", bus.OUT2, 8'h3C);
      cyc(1'b0, 3'd0, 8'h00, 3'd4, 3'd4);
      check("t3_r4_held", bus.OUT1, 8'h3C);

      // 4: write disabled
      cyc(1'b1, 3'd1, 8'h07, 3'd0, 3'd0);
      cyc(1'b0, 3'd1, 8'hFF, 3'd1, 3'd1);
      check("t4_no_byp", bus.OUT1, 8'h07);
      check("t4_busy", {7'd0, bus.BUSY}, 8'h00);
      cyc(1'b0, 3'd0, 8'h00, 3'd1, 3'd1);
      check("t4_r1_held", bus.OUT2, 8'h07);

      // 5: full sweep, read pairs (i, 7-i)
      for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 8'h10 + 8'(i), 3'd0, 3'd0);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
         check($sformatf("t5_out1_r%0d", i), bus.OUT1, 8'h10 + 8'(i));
         check($sformatf("t5_out2_r%0d", 7 - i), bus.OUT2, 8'h17 - 8'(i));
      end

      // X on WRITE must not disturb the array
      cyc(1'bx, 3'd2, 8'hEE, 3'd2, 3'd2);
      cyc(1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
      check("x_write_r2", bus.OUT1, 8'h12);

      // 6: reset coincident with a falling edge carrying a write
      bus.WRITE = 1'b1; bus.INADDRESS = 3'd6; bus.IN = 8'h99;
      bus.OUT1ADDRESS = 3'd6; bus.OUT2ADDRESS = 3'd6;
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("t6_rst_out1", bus.OUT1, 8'h00);
      check("t6_rst_out2", bus.OUT2, 8'h00);
      @(posedge CLK);
      bus.WRITE = 1'b0;
      @(posedge CLK);
      check("t6_hold_out1", bus.OUT1, 8'h00);
      check("t6_hold_out2", bus.OUT2, 8'h00);
      RESET = 1'b0;
      cyc(1'b0, 3'd0, 8'h00, 3'd6, 3'd6);
      check("t6_r6_out1", bus.OUT1, 8'h00);
      check("t6_r6_out2", bus.OUT2, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
